common_fa_tag_alloc: RTL and testbench

Fully-associative tag table with allocate-on-miss, built around the pseudo-LRU picker. It accepts tag lookups and reports hit/miss with the matching entry index. On a miss with allocation requested, it installs the tag in an invalid entry, or in the picker's LRU victim when the table is full. It drives the picker's touch port (`waddr`/`wen`) and valid vector (`dvalid`), and consumes its pick (`qaddr`/`qvalid`).

---
 rtl/common_fa_tag_alloc.sv | 119 +++++++++++
 tb/tb_common_fa_tag_alloc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/common_fa_tag_alloc.sv
// Fully-associative tag table with allocate-on-miss; victim choice is delegated
// to an external pseudo-LRU picker that is touched on every hit or allocation.
module common_fa_tag_alloc #(
  parameter int unsigned SUBJECT_COUNT_LOG2 = 5,
  parameter int unsigned TAG_WIDTH          = 20
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [TAG_WIDTH-1:0]                req_tag,
  input  logic                                req_alloc,
  output logic                                resp_valid,
  input  logic                                resp_ready,
  output logic                                resp_hit,
  output logic                                resp_alloc,
  output logic [SUBJECT_COUNT_LOG2-1:0]       resp_index,
  output logic                                resp_evict_valid,
  output logic [TAG_WIDTH-1:0]                resp_evict_tag,
  input  logic                                flush,
  output logic [SUBJECT_COUNT_LOG2-1:0]       lru_waddr,
  output logic                                lru_wen,
  output logic [(1<<SUBJECT_COUNT_LOG2)-1:0]  lru_dvalid,
  input  logic [SUBJECT_COUNT_LOG2-1:0]       lru_qaddr,
  input  logic                                lru_qvalid
);

  localparam int unsigned N  = 1 << SUBJECT_COUNT_LOG2;
  localparam int unsigned IW = SUBJECT_COUNT_LOG2;

  logic [N-1:0]         valid_q;
  logic [TAG_WIDTH-1:0] tag_q [N];

  logic          fire_c;
  logic          hit_c;
  logic [IW-1:0] hit_idx_c;
  logic          free_c;
  logic [IW-1:0] free_idx_c;
  logic          alloc_c;
  logic          evict_c;
  logic [IW-1:0] target_c;
  logic [IW-1:0] index_c;

  // Parallel match and free-slot search; scanning downward lets the lowest index win.
  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    free_c     = 1'b0;
    free_idx_c = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        hit_c     = 1'b1;
        hit_idx_c = IW'(i);
      end
      if (!valid_q[i]) begin
        free_c     = 1'b1;
        free_idx_c = IW'(i);
      end
    end
  end

  assign req_ready = ~flush & (~resp_valid | resp_ready);
  assign fire_c    = req_valid & req_ready;

  // Prefer an empty slot; only fall back to the picker's victim when the table is full.
  assign alloc_c  = fire_c & ~hit_c & req_alloc & (free_c | lru_qvalid);
  assign evict_c  = alloc_c & ~free_c;
  assign target_c = free_c ? free_idx_c : lru_qaddr;

  always_comb begin
    index_c = '0;
    if (hit_c) begin
      index_c = hit_idx_c;
    end else if (alloc_c) begin
      index_c = target_c;
    end
  end

  assign lru_wen    = fire_c & (hit_c | alloc_c);
  assign lru_waddr  = hit_c ? hit_idx_c : target_c;
  assign lru_dvalid = valid_q;

  // Table storage; flush and fire are mutually exclusive because flush drops req_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int i = 0; i < int'(N); i++) begin
        tag_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (alloc_c) begin
      valid_q[target_c] <= 1'b1;
      tag_q[target_c]   <= req_tag;
    end
  end

  // One-entry response register; fields are only rewritten by a new fire.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid       <= 1'b0;
      resp_hit         <= 1'b0;
      resp_alloc       <= 1'b0;
      resp_index       <= '0;
      resp_evict_valid <= 1'b0;
      resp_evict_tag   <= '0;
    end else if (fire_c) begin
      resp_valid       <= 1'b1;
      resp_hit         <= hit_c;
      resp_alloc       <= alloc_c;
      resp_index       <= index_c;
      resp_evict_valid <= evict_c;
      resp_evict_tag   <= evict_c ? tag_q[lru_qaddr] : '0;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_common_fa_tag_alloc.sv
// Directed + randomized bench for common_fa_tag_alloc with a reference table
// model feeding a response scoreboard queue.
module tb_common_fa_tag_alloc;

  localparam int unsigned IW = 5;
  localparam int unsigned TW = 20;
  localparam int unsigned N  = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic [TW-1:0] req_tag;
  logic          req_alloc;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_hit;
  logic          resp_alloc;
  logic [IW-1:0] resp_index;
  logic          resp_evict_valid;
  logic [TW-1:0] resp_evict_tag;
  logic          flush;
  logic [IW-1:0] lru_waddr;
  logic          lru_wen;
  logic [N-1:0]  lru_dvalid;
  logic [IW-1:0] lru_qaddr;
  logic          lru_qvalid;

  common_fa_tag_alloc #(.SUBJECT_COUNT_LOG2(IW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_alloc(req_alloc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_alloc(resp_alloc), .resp_index(resp_index),
    .resp_evict_valid(resp_evict_valid), .resp_evict_tag(resp_evict_tag),
    .flush(flush), .lru_waddr(lru_waddr), .lru_wen(lru_wen), .lru_dvalid(lru_dvalid),
    .lru_qaddr(lru_qaddr), .lru_qvalid(lru_qvalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          hit;
    logic          alloc;
    logic [IW-1:0] idx;
    logic          ev;
    logic [TW-1:0] evtag;
  } resp_t;

  resp_t         sb[$];
  logic [N-1:0]  mvalid;
  logic [TW-1:0] mtag [N];
  int            checks   = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance past the edge.
  task automatic cyc();
    resp_t         e;
    logic          pending, exp_ready, fire, hit, hasfree, al;
    logic [IW-1:0] hidx, fidx, tgt;
    @(negedge clk);
    pending = (sb.size() != 0);
    chk("resp_valid", 32'(resp_valid), 32'(pending));
    chk("lru_dvalid", 32'(lru_dvalid), 32'(mvalid));
    if (pending) begin
      e = sb[0];
      chk("resp_hit",         32'(resp_hit),         32'(e.hit));
      chk("resp_alloc",       32'(resp_alloc),       32'(e.alloc));
      chk("resp_index",       32'(resp_index),       32'(e.idx));
      chk("resp_evict_valid", 32'(resp_evict_valid), 32'(e.ev));
      chk("resp_evict_tag",   32'(resp_evict_tag),   32'(e.evtag));
      if (resp_ready) void'(sb.pop_front());
    end
    exp_ready = !flush && (!pending || resp_ready);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    fire = req_valid && exp_ready;
    hit = 1'b0; hidx = '0; hasfree = 1'b0; fidx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!hit && mvalid[i] && mtag[i] == req_tag) begin hit = 1'b1; hidx = IW'(i); end
      if (!hasfree && !mvalid[i]) begin hasfree = 1'b1; fidx = IW'(i); end
    end
    al  = fire && !hit && req_alloc && (hasfree || lru_qvalid);
    tgt = hasfree ? fidx : lru_qaddr;
    chk("lru_wen", 32'(lru_wen), 32'(fire && (hit || al)));
    if (fire && (hit || al)) chk("lru_waddr", 32'(lru_waddr), 32'(hit ? hidx : tgt));
    if (fire) begin
      e.hit   = hit;
      e.alloc = al;
      e.idx   = hit ? hidx : (al ? tgt : '0);
      e.ev    = al && !hasfree;
      e.evtag = e.ev ? mtag[lru_qaddr] : '0;
      sb.push_back(e);
      if (al) begin mvalid[tgt] = 1'b1; mtag[tgt] = req_tag; end
    end
    if (flush) mvalid = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [TW-1:0] t, input logic a);
    req_valid = v;
    req_tag   = t;
    req_alloc = a;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    lru_qaddr = '0; lru_qvalid = 1'b0;
    drive(1'b0, '0, 1'b0);
    mvalid = '0;
    for (int i = 0; i < int'(N); i++) mtag[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_fields", 32'({resp_hit, resp_alloc, resp_index, resp_evict_valid}), 32'd0);
    chk("rst_evict_tag", 32'(resp_evict_tag), 32'd0);
    chk("rst_lru_wen", 32'(lru_wen), 32'd0);
    chk("rst_lru_dvalid", 32'(lru_dvalid), 32'd0);
    resetn = 1'b1;

    // First allocation lands in entry 0, then an immediate same-tag hit.
    drive(1'b1, 20'h00123, 1'b1);
    cyc();
    chk("alloc0_alloc", 32'(resp_alloc), 32'd1);
    chk("alloc0_index", 32'(resp_index), 32'd0);
    chk("alloc0_evict", 32'(resp_evict_valid), 32'd0);
    cyc();
    chk("hit0_hit", 32'(resp_hit), 32'd1);
    chk("hit0_index", 32'(resp_index), 32'd0);

    // Flush while a response is pending and a request is waiting.
    resp_ready = 1'b0;
    cyc();
    flush = 1'b1; resp_ready = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, 20'h00123, 1'b0);
    cyc();
    chk("flush_dvalid", 32'(lru_dvalid), 32'd0);
    drive(1'b1, 20'h00123, 1'b0);
    cyc();
    chk("flush_miss_hit", 32'(resp_hit), 32'd0);
    chk("flush_miss_alloc", 32'(resp_alloc), 32'd0);

    // Fill the table, then evict through the picker's victim.
    for (int i = 0; i < int'(N); i++) begin
      drive(1'b1, TW'(20'h00100 + i), 1'b1);
      cyc();
    end
    chk("fill_last_index", 32'(resp_index), 32'd31);
    lru_qaddr = 5'd7; lru_qvalid = 1'b1;
    drive(1'b1, 20'h00999, 1'b1);
    cyc();
    chk("evict_index", 32'(resp_index), 32'd7);
    chk("evict_valid", 32'(resp_evict_valid), 32'd1);
    chk("evict_tag", 32'(resp_evict_tag), 32'h107);
    drive(1'b1, 20'h00107, 1'b0);
    cyc();
    chk("evicted_miss", 32'(resp_hit), 32'd0);
    lru_qvalid = 1'b0;
    drive(1'b1, 20'h00555, 1'b1);
    cyc();
    chk("noq_alloc", 32'(resp_alloc), 32'd0);
    chk("noq_hit", 32'(resp_hit), 32'd0);
    drive(1'b1, 20'h00999, 1'b0);
    cyc();
    chk("victim_hit_index", 32'({resp_hit, resp_index}), 32'({1'b1, 5'd7}));

    // Backpressure for three cycles, then release fires on the consuming edge.
    resp_ready = 1'b0;
    drive(1'b1, 20'h00110, 1'b0);
    repeat (3) cyc();
    resp_ready = 1'b1;
    cyc();
    chk("release_hit_index", 32'({resp_hit, resp_index}), 32'({1'b1, 5'd16}));

    // Randomized traffic over a small tag space to mix hits, misses and evictions.
    for (int k = 0; k < 200; k++) begin
      drive(1'($urandom_range(0, 3) != 0), TW'(20'h00200 + $urandom_range(0, 40)),
            1'($urandom_range(0, 1)));
      lru_qaddr  = IW'($urandom_range(0, int'(N) - 1));
      lru_qvalid = 1'($urandom_range(0, 3) != 0);
      resp_ready = 1'($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 31) == 0);
      cyc();
    end
    flush = 1'b0; resp_ready = 1'b1;
    drive(1'b0, '0, 1'b0);
    repeat (2) cyc();

    // Reset mid-operation drops the pending response and empties the table.
    drive(1'b1, 20'h00777, 1'b1);
    lru_qvalid = 1'b1;
    cyc();
    drive(1'b0, '0, 1'b0);
    resetn = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_dvalid", 32'(lru_dvalid), 32'd0);
    chk("midrst_wen", 32'(lru_wen), 32'd0);
    sb.delete();
    mvalid = '0;
    for (int i = 0; i < int'(N); i++) mtag[i] = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 20'h00777, 1'b0);
    cyc();
    chk("post_rst_miss", 32'(resp_hit), 32'd0);
    drive(1'b0, '0, 1'b0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
